// File: rtl/vga_pkg.sv
// Shared VGA raster constants, flag bundle and timing helper for the display pipeline.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;

   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   localparam logic POL_LOW  = 1'b0;
   localparam logic POL_HIGH = 1'b1;

   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
      logic line_start;
      logic frame_start;
   } vga_flags_t;

   function automatic int unsigned vga_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/pix_div.sv
// Generic clock-enable divider: tick_o is high for one clock out of every DIV.
// With DIV=1 tick_o stays high permanently.
module pix_div #(
   parameter int unsigned DIV = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   if (DIV < 1) begin : g_bad_div
      $error("pix_div: DIV must be >= 1");
   end

   logic [W-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel enable, coherent registered position/sync/blank
// flags, line/frame strobes and a run-gated frame-rate animation counter.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned CW          = 10,
   parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
   parameter int unsigned H_FP        = H_FP_DEF,
   parameter int unsigned H_SYNC      = H_SYNC_DEF,
   parameter int unsigned H_BP        = H_BP_DEF,
   parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
   parameter int unsigned V_FP        = V_FP_DEF,
   parameter int unsigned V_SYNC      = V_SYNC_DEF,
   parameter int unsigned V_BP        = V_BP_DEF,
   parameter logic        HS_POL      = POL_LOW,
   parameter logic        VS_POL      = POL_LOW,
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned FRAME_DIV   = 1,
   parameter int unsigned ANIM_STATES = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           run_i,
   output logic                           pix_en_o,
   output logic [CW-1:0]                  x_o,
   output logic [CW-1:0]                  y_o,
   output logic                           hs_o,
   output logic                           vs_o,
   output logic                           active_o,
   output logic                           blank_n_o,
   output logic                           sync_n_o,
   output logic                           line_start_o,
   output logic                           frame_start_o,
   output logic                           anim_tick_o,
   output logic [$clog2(ANIM_STATES)-1:0] anim_state_o
);

   localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;
   localparam int unsigned AW      = $clog2(ANIM_STATES);
   localparam int unsigned FW      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   localparam logic [CW-1:0] X_LAST     = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] Y_LAST     = CW'(V_TOTAL - 1);
   localparam logic [FW-1:0] FCNT_LAST  = FW'(FRAME_DIV - 1);
   localparam logic [AW-1:0] STATE_LAST = AW'(ANIM_STATES - 1);

   if (H_TOTAL > 2 ** CW || V_TOTAL > 2 ** CW) begin : g_bad_cw
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit in CW bits");
   end
   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
   end
   if (FRAME_DIV < 1) begin : g_bad_frame_div
      $error("vga_timing_gen: FRAME_DIV must be >= 1");
   end
   if (ANIM_STATES < 2) begin : g_bad_anim
      $error("vga_timing_gen: ANIM_STATES must be >= 2");
   end

   logic            tick;
   logic [CW-1:0]   x_q, x_d, x_nxt;
   logic [CW-1:0]   y_q, y_d, y_nxt;
   vga_flags_t      flags_q, flags_d, flags_nxt;
   logic            pix_en_q;
   logic [FW-1:0]   fcnt_q, fcnt_d;
   logic            anim_tick_q, anim_tick_d;
   logic [AW-1:0]   anim_state_q, anim_state_d;

   pix_div #(
      .DIV (CLK_DIV)
   ) u_pix_div (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_o (tick)
   );

   // Flags are derived from the position about to be loaded so they land with x/y.
   always_comb begin
      x_nxt = x_q + 1'b1;
      y_nxt = y_q;
      if (x_q == X_LAST) begin
         x_nxt = '0;
         y_nxt = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end
      flags_nxt.hs          = ((32'(x_nxt) >= HS_BEG) && (32'(x_nxt) < HS_END)) ? HS_POL : ~HS_POL;
      flags_nxt.vs          = ((32'(y_nxt) >= VS_BEG) && (32'(y_nxt) < VS_END)) ? VS_POL : ~VS_POL;
      flags_nxt.active      = (32'(x_nxt) < H_ACTIVE) && (32'(y_nxt) < V_ACTIVE);
      flags_nxt.line_start  = (x_nxt == '0);
      flags_nxt.frame_start = (x_nxt == '0) && (y_nxt == '0);
   end

   always_comb begin
      x_d                 = x_q;
      y_d                 = y_q;
      flags_d             = flags_q;
      flags_d.line_start  = 1'b0;
      flags_d.frame_start = 1'b0;
      if (tick) begin
         x_d     = x_nxt;
         y_d     = y_nxt;
         flags_d = flags_nxt;
      end
   end

   // run_i only matters on the registered frame_start, so mid-frame changes wait a frame.
   always_comb begin
      fcnt_d       = fcnt_q;
      anim_tick_d  = 1'b0;
      anim_state_d = anim_state_q;
      if (flags_q.frame_start && run_i) begin
         if (fcnt_q == FCNT_LAST) begin
            fcnt_d       = '0;
            anim_tick_d  = 1'b1;
            anim_state_d = (anim_state_q == STATE_LAST) ? '0 : anim_state_q + 1'b1;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_q          <= X_LAST;
         y_q          <= Y_LAST;
         flags_q      <= '{hs: ~HS_POL, vs: ~VS_POL, active: 1'b0, line_start: 1'b0,
                           frame_start: 1'b0};
         pix_en_q     <= 1'b0;
         fcnt_q       <= '0;
         anim_tick_q  <= 1'b0;
         anim_state_q <= '0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         flags_q      <= flags_d;
         pix_en_q     <= tick;
         fcnt_q       <= fcnt_d;
         anim_tick_q  <= anim_tick_d;
         anim_state_q <= anim_state_d;
      end
   end

   assign pix_en_o      = pix_en_q;
   assign x_o           = x_q;
   assign y_o           = y_q;
   assign hs_o          = flags_q.hs;
   assign vs_o          = flags_q.vs;
   assign active_o      = flags_q.active;
   assign blank_n_o     = flags_q.active;
   assign sync_n_o      = 1'b1;
   assign line_start_o  = flags_q.line_start;
   assign frame_start_o = flags_q.frame_start;
   assign anim_tick_o   = anim_tick_q;
   assign anim_state_o  = anim_state_q;

endmodule
